// File: rtl/microwave_pkg.sv
// Shared types and cycle-count helpers for the microwave alarm path.
package microwave_pkg;

  typedef enum logic [1:0] {IDLE, BEEP, GAP} buzz_state_t;

  function automatic int half_cycles(input int clk_freq, input int tone_hz);
    return clk_freq / (2 * tone_hz);
  endfunction

  function automatic int ms_cycles(input int clk_freq, input int ms);
    return clk_freq / 1000 * ms;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/done_buzzer_tone_gen.sv
// Square-wave generator: wave toggles every HALF_CYC cycles while enabled.
module tone_gen
  import microwave_pkg::*;
#(
  parameter int HALF_CYC = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic wave
);

  localparam int DIV_W = cnt_width(HALF_CYC, 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             wave_q, wave_d;

  // en and restart describe the next cycle, so wave is high on the first burst cycle.
  always_comb begin
    div_d  = div_q;
    wave_d = wave_q;
    if (!en) begin
      div_d  = '0;
      wave_d = 1'b0;
    end else if (restart) begin
      div_d  = '0;
      wave_d = 1'b1;
    end else if (div_q == DIV_W'(HALF_CYC - 1)) begin
      div_d  = '0;
      wave_d = ~wave_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/done_buzzer.sv
// Alarm stage: plays BEEP_COUNT tone bursts on a rising edge of done; cancel aborts.
module done_buzzer
  import microwave_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 200,
  parameter int BEEP_COUNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic done,
  input  logic cancel,
  output logic buzzer,
  output logic alarm_active
);

  localparam int HALF_CYC = half_cycles(CLK_FREQ, TONE_HZ);
  localparam int BEEP_CYC = ms_cycles(CLK_FREQ, BEEP_MS);
  localparam int GAP_CYC  = ms_cycles(CLK_FREQ, GAP_MS);
  localparam int CNT_W    = cnt_width(BEEP_CYC, GAP_CYC);

  buzz_state_t      state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [3:0]       beep_q, beep_d;
  logic             prev_done_q, prev_done_d;
  logic             armed_q, armed_d;
  logic             alarm_q, alarm_d;
  logic             trig;
  logic             start_burst;

  // armed_q blocks a false edge when done is already high as reset releases.
  always_comb begin
    trig        = done & ~prev_done_q & armed_q;
    state_d     = state_q;
    dur_d       = dur_q;
    beep_d      = beep_q;
    start_burst = 1'b0;
    if (cancel) begin
      state_d = IDLE;
      dur_d   = '0;
      beep_d  = '0;
    end else if (trig) begin
      state_d     = BEEP;
      dur_d       = '0;
      beep_d      = 4'd1;
      start_burst = 1'b1;
    end else begin
      case (state_q)
        BEEP: begin
          if (dur_q == CNT_W'(BEEP_CYC - 1)) begin
            dur_d = '0;
            if (beep_q == 4'(BEEP_COUNT)) begin
              state_d = IDLE;
              beep_d  = '0;
            end else begin
              state_d = GAP;
            end
          end else begin
            dur_d = dur_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (dur_q == CNT_W'(GAP_CYC - 1)) begin
            state_d     = BEEP;
            dur_d       = '0;
            beep_d      = beep_q + 4'd1;
            start_burst = 1'b1;
          end else begin
            dur_d = dur_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    alarm_d     = (state_d != IDLE);
    prev_done_d = done;
    armed_d     = armed_q | ~done;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      beep_q      <= '0;
      prev_done_q <= 1'b0;
      armed_q     <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      beep_q      <= beep_d;
      prev_done_q <= prev_done_d;
      armed_q     <= armed_d;
      alarm_q     <= alarm_d;
    end
  end

  tone_gen #(
    .HALF_CYC(HALF_CYC)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .en     (state_d == BEEP),
    .restart(start_burst),
    .wave   (buzzer)
  );

  assign alarm_active = alarm_q;

endmodule
